fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the five-stage pipelined CPU. Tracks destination-register information through ID/EX, EX/MEM and MEM/WB and drives the 2-bit select of the two ALU-operand 4:1 forwarding multiplexers. Detects load-use hazards and requests a one-cycle stall with bubble insertion. Honours an external freeze (memory wait) and a branch flush.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fwd_sel.sv | 28 ++
 rtl/fwd_hazard_ctrl.sv | 90 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the forwarding/hazard unit: mux select codes and
// shadow-register entry layouts tracked alongside ID/EX, EX/MEM and MEM/WB.
package cpu_pkg;
   // Register indices are held at this width internally. Narrower REG_AW values are zero-extended.
   localparam int REG_IDX_W = 8;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rs1;
      reg_idx_t rs2;
      logic     rs1_use;
      logic     rs2_use;
      reg_idx_t rd;
      logic     regwrite;
      logic     memread;
   } idex_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      logic     regwrite;
   } wb_ent_t;
endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand. The EX/MEM result wins over MEM/WB
// because it is the younger write. x0 is never a forwarding source.
module fwd_sel
   import cpu_pkg::*;
(
   input  logic       src_valid,
   input  logic       src_use,
   input  reg_idx_t   src_rs,
   input  wb_ent_t    exmem,
   input  wb_ent_t    memwb,
   output logic [1:0] sel
);
   logic hit_exmem;
   logic hit_memwb;

   assign hit_exmem = src_valid & src_use & exmem.valid & exmem.regwrite &
                      (exmem.rd != '0) & (exmem.rd == src_rs);
   assign hit_memwb = src_valid & src_use & memwb.valid & memwb.regwrite &
                      (memwb.rd != '0) & (memwb.rd == src_rs);

   always_comb begin
      sel = FWD_REG;
      if (hit_exmem)
         sel = FWD_EXMEM;
      else if (hit_memwb)
         sel = FWD_WB;
   end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the five-stage pipeline.
// It shadows rd/regwrite through ID/EX, EX/MEM and MEM/WB and drives the operand-mux selects and the stall request.
module fwd_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rs1_use_i,
   input  logic              id_rs2_use_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              freeze_i,
   input  logic              flush_i,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);
   idex_t   id_ent;
   idex_t   idex;
   wb_ent_t exmem;
   wb_ent_t memwb;

   always_comb begin
      id_ent          = '0;
      id_ent.valid    = id_valid_i;
      id_ent.rs1      = reg_idx_t'(id_rs1_i);
      id_ent.rs2      = reg_idx_t'(id_rs2_i);
      id_ent.rs1_use  = id_rs1_use_i;
      id_ent.rs2_use  = id_rs2_use_i;
      id_ent.rd       = reg_idx_t'(id_rd_i);
      id_ent.regwrite = id_regwrite_i;
      id_ent.memread  = id_memread_i;
   end

   // A freeze suppresses the stall so that a held pipeline is not counted.
   assign stall_o = id_valid_i & idex.valid & idex.memread & (idex.rd != '0) &
                    ((id_rs1_use_i & (id_ent.rs1 == idex.rd)) |
                     (id_rs2_use_i & (id_ent.rs2 == idex.rd))) &
                    ~freeze_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idex        <= '0;
         exmem       <= '0;
         memwb       <= '0;
         stall_cnt_o <= '0;
      end else if (!freeze_i) begin
         exmem.valid    <= idex.valid;
         exmem.rd       <= idex.rd;
         exmem.regwrite <= idex.regwrite;
         memwb          <= exmem;
         // A flush or a stall inserts a bubble. A flush wins, so the stall is not counted.
         if (flush_i || stall_o)
            idex <= '0;
         else
            idex <= id_ent;
         if (stall_o && !flush_i && !(&stall_cnt_o))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

   fwd_sel u_fwd_a (
      .src_valid (idex.valid),
      .src_use   (idex.rs1_use),
      .src_rs    (idex.rs1),
      .exmem     (exmem),
      .memwb     (memwb),
      .sel       (fwd_a_o)
   );

   fwd_sel u_fwd_b (
      .src_valid (idex.valid),
      .src_use   (idex.rs2_use),
      .src_rs    (idex.rs2),
      .exmem     (exmem),
      .memwb     (memwb),
      .sel       (fwd_b_o)
   );

   a_no_sel3: assert property (@(posedge clk_i) disable iff (!rst_i)
                               (fwd_a_o != 2'b11) && (fwd_b_o != 2'b11));
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scenario bench for fwd_hazard_ctrl. Each row drives one ID-stage cycle and pushes its expected outputs.
// The outputs are popped and compared at the following falling edge.
module tb_fwd_hazard_ctrl;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 3;

   typedef struct packed {
      logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
      logic [4:0] rd; logic rw; logic mr;
   } ins_t;

   typedef struct {
      ins_t i; logic frz; logic fl;
      logic [1:0] ea; logic [1:0] eb; logic es; logic [CNT_W-1:0] ec;
   } row_t;

   typedef logic [CNT_W+4:0] obs_t;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              id_valid_i = 1'b0;
   logic [REG_AW-1:0] id_rs1_i = '0;
   logic [REG_AW-1:0] id_rs2_i = '0;
   logic              id_rs1_use_i = 1'b0;
   logic              id_rs2_use_i = 1'b0;
   logic [REG_AW-1:0] id_rd_i = '0;
   logic              id_regwrite_i = 1'b0;
   logic              id_memread_i = 1'b0;
   logic              freeze_i = 1'b0;
   logic              flush_i = 1'b0;
   logic [1:0]        fwd_a_o;
   logic [1:0]        fwd_b_o;
   logic              stall_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   int   n_chk  = 0;
   int   n_pass = 0;
   obs_t sb[$];
   obs_t got;
   obs_t exp_v;

   fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .id_valid_i    (id_valid_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rs1_use_i  (id_rs1_use_i),
      .id_rs2_use_i  (id_rs2_use_i),
      .id_rd_i       (id_rd_i),
      .id_regwrite_i (id_regwrite_i),
      .id_memread_i  (id_memread_i),
      .freeze_i      (freeze_i),
      .flush_i       (flush_i),
      .fwd_a_o       (fwd_a_o),
      .fwd_b_o       (fwd_b_o),
      .stall_o       (stall_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic ins_t NOP();
      return '0;
   endfunction

   function automatic ins_t ALU(int rd, int a, int b);
      ins_t x = '0;
      x.v = 1'b1; x.rs1 = 5'(a); x.u1 = 1'b1; x.rs2 = 5'(b); x.u2 = 1'b1;
      x.rd = 5'(rd); x.rw = 1'b1;
      return x;
   endfunction

   function automatic ins_t LD(int rd, int a);
      ins_t x = '0;
      x.v = 1'b1; x.rs1 = 5'(a); x.u1 = 1'b1; x.rd = 5'(rd); x.rw = 1'b1; x.mr = 1'b1;
      return x;
   endfunction

   function automatic row_t R(ins_t i, logic [1:0] ea, logic [1:0] eb, logic es, int ec,
                              logic frz = 1'b0, logic fl = 1'b0);
      row_t r;
      r.i = i; r.frz = frz; r.fl = fl; r.ea = ea; r.eb = eb; r.es = es; r.ec = CNT_W'(ec);
      return r;
   endfunction

   task automatic apply(input row_t r);
      id_valid_i = r.i.v;  id_rs1_i = r.i.rs1; id_rs1_use_i = r.i.u1;
      id_rs2_i = r.i.rs2;  id_rs2_use_i = r.i.u2; id_rd_i = r.i.rd;
      id_regwrite_i = r.i.rw; id_memread_i = r.i.mr;
      freeze_i = r.frz; flush_i = r.fl;
      sb.push_back({r.ea, r.eb, r.es, r.ec});
   endtask

   task automatic do_reset();
      apply(R(NOP(), 2'b00, 2'b00, 1'b0, 0));
      void'(sb.pop_front());
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      row_t rows[$];
      rst_i = 1'b0;
      apply(R(ALU(6, 5, 4), 2'b00, 2'b00, 1'b0, 0));
      #2;
      got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL reset_state got=%b exp=%b", got, exp_v);
      else n_pass++;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      rows.push_back(R(ALU(1, 2, 3), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b00, 2'b00, 1'b0, 0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL reset_idle[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      do_reset();
      rows.push_back(R(ALU(5, 1, 2), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(6, 5, 4), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b10, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b00, 2'b00, 1'b0, 0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL back_to_back[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_distance_two();
      row_t rows[$];
      do_reset();
      rows.push_back(R(ALU(7, 1, 2), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(8, 1, 7), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b00, 2'b01, 1'b0, 0));
      rows.push_back(R(ALU(7, 1, 1), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(7, 2, 2), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(9, 7, 7), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b10, 2'b10, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b00, 2'b00, 1'b0, 0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL distance_two[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_load_use();
      row_t rows[$];
      do_reset();
      rows.push_back(R(LD(3, 1),     2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(4, 3, 2), 2'b00, 2'b00, 1'b1, 0));
      rows.push_back(R(ALU(4, 3, 2), 2'b00, 2'b00, 1'b0, 1));
      rows.push_back(R(NOP(),        2'b01, 2'b00, 1'b0, 1));
      rows.push_back(R(NOP(),        2'b00, 2'b00, 1'b0, 1));
      rows.push_back(R(LD(3, 1),     2'b00, 2'b00, 1'b0, 1));
      rows.push_back(R(ALU(5, 1, 3), 2'b00, 2'b00, 1'b1, 1));
      rows.push_back(R(ALU(5, 1, 3), 2'b00, 2'b00, 1'b0, 2));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL load_use[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_x0();
      row_t rows[$];
      do_reset();
      rows.push_back(R(LD(0, 1),     2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(4, 0, 0), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(0, 1, 1), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(5, 0, 0), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b00, 2'b00, 1'b0, 0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL x0[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_freeze();
      row_t rows[$];
      do_reset();
      rows.push_back(R(ALU(5, 1, 2), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(6, 5, 4), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b10, 2'b00, 1'b0, 0, 1'b1));
      rows.push_back(R(NOP(),        2'b10, 2'b00, 1'b0, 0, 1'b1));
      rows.push_back(R(NOP(),        2'b10, 2'b00, 1'b0, 0, 1'b1));
      rows.push_back(R(NOP(),        2'b10, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),        2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(LD(3, 1),     2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(4, 3, 2), 2'b00, 2'b00, 1'b0, 0, 1'b1));
      rows.push_back(R(ALU(4, 3, 2), 2'b00, 2'b00, 1'b1, 0));
      rows.push_back(R(ALU(4, 3, 2), 2'b00, 2'b00, 1'b0, 1));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL freeze[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_flush_stall();
      row_t rows[$];
      do_reset();
      rows.push_back(R(LD(3, 1),      2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(4, 3, 2),  2'b00, 2'b00, 1'b1, 0, 1'b0, 1'b1));
      rows.push_back(R(ALU(4, 3, 2),  2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),         2'b01, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(9, 1, 1),  2'b00, 2'b00, 1'b0, 0, 1'b0, 1'b1));
      rows.push_back(R(ALU(10, 9, 1), 2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(NOP(),         2'b00, 2'b00, 1'b0, 0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL flush_stall[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_saturation();
      row_t rows[$];
      int   sat;
      do_reset();
      sat = (1 << CNT_W) - 1;
      // A load that reads its own destination re-stalls on every other cycle.
      rows.push_back(R(LD(3, 3), 2'b00, 2'b00, 1'b0, 0));
      for (int k = 1; k <= 20; k++) begin
         if (k % 2 == 1)
            rows.push_back(R(LD(3, 3), (k >= 3) ? 2'b01 : 2'b00, 2'b00, 1'b1,
                             ((k - 1) / 2 > sat) ? sat : (k - 1) / 2));
         else
            rows.push_back(R(LD(3, 3), 2'b00, 2'b00, 1'b0, (k / 2 > sat) ? sat : k / 2));
      end
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL saturation[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset_mid_stall();
      row_t rows[$];
      do_reset();
      rows.push_back(R(LD(3, 1),     2'b00, 2'b00, 1'b0, 0));
      rows.push_back(R(ALU(4, 3, 2), 2'b00, 2'b00, 1'b1, 0));
      rows.push_back(R(ALU(4, 3, 2), 2'b00, 2'b00, 1'b0, 1));
      rows.push_back(R(LD(3, 4),     2'b01, 2'b00, 1'b0, 1));
      rows.push_back(R(ALU(5, 3, 2), 2'b10, 2'b00, 1'b1, 1));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(negedge clk_i);
         got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
         exp_v = sb.pop_front();
         n_chk++;
         if (got !== exp_v) $display("FAIL reset_mid_stall[%0d] got=%b exp=%b", k, got, exp_v);
         else n_pass++;
         if (k < rows.size() - 1) begin
            @(posedge clk_i); #1;
         end
      end
      // Reset is asserted between clock edges. The outputs must clear without waiting for an edge.
      sb.push_back('0);
      #1 rst_i = 1'b0;
      #1;
      got = {fwd_a_o, fwd_b_o, stall_o, stall_cnt_o};
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL async_reset got=%b exp=%b", got, exp_v);
      else n_pass++;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_distance_two();
      test_load_use();
      test_x0();
      test_freeze();
      test_flush_stall();
      test_saturation();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
